// File: rtl/sprite_line_scheduler_if.sv
// Sprite scheduler bus: line trigger, object table read port, slot table write port, status.
interface sprite_line_scheduler_if #(
   parameter int IDX_W  = 7,
   parameter int SLOT_W = 3
);
   logic              line_start;
   logic [9:0]        target_line;
   logic              obj_rd_en;
   logic [IDX_W-1:0]  obj_rd_addr;
   logic [29:0]       obj_rd_data;
   logic              slot_clear;
   logic              slot_wr;
   logic [SLOT_W-1:0] slot_idx;
   logic [11:0]       slot_x;
   logic [4:0]        slot_sprite;
   logic [4:0]        slot_row;
   logic              busy;
   logic              sched_done;
   logic [SLOT_W:0]   slot_count;
   logic              overflow;

   modport master (
      input  line_start, target_line, obj_rd_data,
      output obj_rd_en, obj_rd_addr, slot_clear, slot_wr, slot_idx, slot_x,
             slot_sprite, slot_row, busy, sched_done, slot_count, overflow
   );

   modport slave (
      output line_start, target_line, obj_rd_data,
      input  obj_rd_en, obj_rd_addr, slot_clear, slot_wr, slot_idx, slot_x,
             slot_sprite, slot_row, busy, sched_done, slot_count, overflow
   );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: sequenced object table scan filling up to SLOTS slot entries.
// Optional SCHED_EARLY_EXIT_EN: stop reading once all slots are filled (overflow then held 0).
module sprite_line_scheduler #(
   parameter int MAX_OBJECTS   = 100,
   parameter int SLOTS         = 8,
   parameter int SPRITE_HEIGHT = 32,
   parameter int IDX_W         = 7,
   parameter int SLOT_W        = 3
) (
   input logic                     clk,
   input logic                     reset,
   sprite_line_scheduler_if.master bus
);
`ifdef SCHED_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif
   localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(MAX_OBJECTS - 1);
   localparam logic [SLOT_W:0]  FULL_CNT  = (SLOT_W + 1)'(SLOTS);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
   state_t state, state_nxt;

   logic [9:0]       line_q;
   logic [SLOT_W:0]  count;
   logic [IDX_W-1:0] addr;
   logic             ovf, rd_vld, drain_ph, early_q, done_nxt, drain_fin, full, hit;
   logic [12:0]      line13, y13, y_end;

   // 13-bit compare so a y near 4095 cannot wrap around onto a low line
   assign line13 = {3'b0, line_q};
   assign y13    = {1'b0, bus.obj_rd_data[17:6]};
   assign y_end  = y13 + 13'(SPRITE_HEIGHT);
   assign hit    = rd_vld && bus.obj_rd_data[0] && (line13 >= y13) && (line13 < y_end);
   assign full   = (count == FULL_CNT);

   // Normal drain waits two cycles so the last object's write lands before done;
   // an early exit has nothing left to write and drains in one.
   assign drain_fin = drain_ph || (EARLY_EXIT && early_q);

   assign bus.obj_rd_en   = (state == SCAN);
   assign bus.obj_rd_addr = addr;
   assign bus.busy        = (state != IDLE);
   assign bus.slot_count  = count;
   assign bus.overflow    = ovf;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      if (bus.line_start) begin
         state_nxt = SCAN;
      end else begin
         case (state)
            IDLE: ;
            SCAN: if ((EARLY_EXIT && full) || addr == LAST_ADDR) state_nxt = DRAIN;
            DRAIN: if (drain_fin) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_q          <= '0;
         count           <= '0;
         addr            <= '0;
         ovf             <= 1'b0;
         rd_vld          <= 1'b0;
         drain_ph        <= 1'b0;
         early_q         <= 1'b0;
         bus.slot_clear  <= 1'b0;
         bus.slot_wr     <= 1'b0;
         bus.slot_idx    <= '0;
         bus.slot_x      <= '0;
         bus.slot_sprite <= '0;
         bus.slot_row    <= '0;
         bus.sched_done  <= 1'b0;
      end else begin
         bus.slot_clear  <= bus.line_start;
         bus.slot_wr     <= 1'b0;
         bus.slot_idx    <= '0;
         bus.slot_x      <= '0;
         bus.slot_sprite <= '0;
         bus.slot_row    <= '0;
         bus.sched_done  <= done_nxt;
         // a restart drops whatever read is still in flight
         rd_vld          <= (state == SCAN) && !bus.line_start;
         drain_ph        <= (state == DRAIN) && !drain_ph && !bus.line_start;
         if (bus.line_start) begin
            line_q  <= bus.target_line;
            count   <= '0;
            addr    <= '0;
            ovf     <= 1'b0;
            early_q <= 1'b0;
         end else begin
            if (state == SCAN) begin
               addr    <= (state_nxt == DRAIN) ? '0 : addr + 1'b1;
               early_q <= full;
            end
            if (hit) begin
               if (!full) begin
                  bus.slot_wr     <= 1'b1;
                  bus.slot_idx    <= count[SLOT_W-1:0];
                  bus.slot_x      <= bus.obj_rd_data[29:18];
                  bus.slot_sprite <= bus.obj_rd_data[5:1];
                  bus.slot_row    <= line_q[4:0] - bus.obj_rd_data[10:6];
                  count           <= count + 1'b1;
               end else if (!EARLY_EXIT) begin
                  ovf <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler: directed and random object tables vs a list-based model.
`timescale 1ns/1ps
module tb_sprite_line_scheduler;
   localparam int MAX    = 100;
   localparam int SLOTS  = 8;
   localparam int IDX_W  = 7;
   localparam int SLOT_W = 3;
`ifdef SCHED_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [29:0] mem [MAX];

   sprite_line_scheduler_if #(.IDX_W(IDX_W), .SLOT_W(SLOT_W)) bus ();

   sprite_line_scheduler #(
      .MAX_OBJECTS(MAX), .SLOTS(SLOTS), .SPRITE_HEIGHT(32), .IDX_W(IDX_W), .SLOT_W(SLOT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.master)
   );

   always #10 clk = ~clk;

   // object table RAM: data valid the cycle after the address
   always @(posedge clk) if (bus.obj_rd_en) bus.obj_rd_data <= mem[bus.obj_rd_addr];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [29:0] obj(input int x, input int y, input int spr, input int act);
      logic [29:0] o;
      o = {x[11:0], y[11:0], spr[4:0], act[0]};
      return o;
   endfunction

   function automatic logic [63:0] pack(input int n, input int idx, input int x, input int s, input int r);
      return {16'(n), 8'(idx), 16'(x), 8'(s), 8'(r)};
   endfunction

   task automatic clear_table();
      for (int i = 0; i < MAX; i++) mem[i] = '0;
   endtask

   task automatic gen_table(input int line, input int dens);
      for (int i = 0; i < MAX; i++) begin
         int r, y;
         r = int'($urandom_range(0, 9));
         if (r < 7)      y = line + int'($urandom_range(0, 45)) - 38;
         else if (r < 9) y = int'($urandom_range(0, 4095));
         else            y = 4095 - int'($urandom_range(0, 7));
         if (y < 0) y = 0;
         mem[i] = obj(int'($urandom_range(0, 4095)), y, int'($urandom_range(0, 31)),
                      (int'($urandom_range(0, 99)) < dens) ? 1 : 0);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, {bus.obj_rd_en, bus.obj_rd_addr, bus.slot_clear, bus.slot_wr, bus.slot_idx,
                bus.slot_x, bus.slot_sprite, bus.slot_row, bus.busy, bus.sched_done,
                bus.slot_count, bus.overflow}, 64'd0);
   endtask

   // Start a scan and let it run ncyc cycles; it must stay busy with no done.
   task automatic partial(input int line, input int ncyc);
      int bad;
      bad = 0;
      @(negedge clk);
      bus.line_start = 1'b1;
      bus.target_line = 10'(line);
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         bus.line_start = 1'b0;
         if (bus.sched_done || !bus.busy) bad++;
      end
      chk("partial_busy_no_done", bad, 0);
   endtask

   // Full scan of one line, compared against the hit list built from the table.
   task automatic scan_line(input int line, input string tag);
      int hk[$];
      int on[$];
      logic [63:0] ow[$];
      int nw, exp_done, exp_rd, done_n, rd_n, bad_rd, bad_clr, bad_idle, bad_busy, y;
      for (int i = 0; i < MAX; i++) begin
         y = int'(mem[i][17:6]);
         if (mem[i][0] && line >= y && line < y + 32) hk.push_back(i);
      end
      nw = (hk.size() < SLOTS) ? hk.size() : SLOTS;
      exp_done = MAX + 3;
      exp_rd   = MAX;
      if (EARLY && hk.size() >= SLOTS) begin
         if (hk[SLOTS-1] <= MAX - 3) begin
            exp_done = hk[SLOTS-1] + 5;
            exp_rd   = hk[SLOTS-1] + 3;
         end
      end

      @(negedge clk);
      bus.line_start = 1'b1;
      bus.target_line = 10'(line);
      done_n = -1; rd_n = 0; bad_rd = 0; bad_clr = 0; bad_idle = 0; bad_busy = 0;
      for (int n = 1; n <= MAX + 10; n++) begin
         @(negedge clk);
         bus.line_start = 1'b0;
         if (n == 1) begin
            chk({tag, "/clear_t1"}, bus.slot_clear, 1);
            chk({tag, "/rd_t1"}, {bus.obj_rd_en, bus.obj_rd_addr}, {1'b1, 7'd0});
         end else if (bus.slot_clear) bad_clr++;
         if (bus.obj_rd_en) begin
            if (int'(bus.obj_rd_addr) != n - 1) bad_rd++;
            rd_n++;
         end
         if (bus.slot_wr) begin
            on.push_back(n);
            ow.push_back(pack(n, int'(bus.slot_idx), int'(bus.slot_x),
                              int'(bus.slot_sprite), int'(bus.slot_row)));
         end else if ({bus.slot_idx, bus.slot_x, bus.slot_sprite, bus.slot_row} != '0) bad_idle++;
         if (bus.sched_done) begin
            done_n = n;
            break;
         end
         if (!bus.busy) bad_busy++;
      end
      chk({tag, "/done_cycle"}, done_n, exp_done);
      chk({tag, "/busy_at_done"}, bus.busy, 0);
      chk({tag, "/slot_count"}, bus.slot_count, nw);
      chk({tag, "/overflow"}, bus.overflow, (!EARLY && hk.size() > SLOTS) ? 1 : 0);
      chk({tag, "/reads"}, rd_n, exp_rd);
      chk({tag, "/rd_addr_seq"}, bad_rd, 0);
      chk({tag, "/extra_clear"}, bad_clr, 0);
      chk({tag, "/idle_fields"}, bad_idle, 0);
      chk({tag, "/busy_during"}, bad_busy, 0);
      chk({tag, "/num_writes"}, ow.size(), nw);
      for (int j = 0; j < nw && j < ow.size(); j++) begin
         y = int'(mem[hk[j]][17:6]);
         chk({tag, "/write"}, ow[j], pack(hk[j] + 3, j, int'(mem[hk[j]][29:18]),
                                          int'(mem[hk[j]][5:1]), (line - y) % 32));
      end
      @(negedge clk);
      chk({tag, "/done_pulse"}, bus.sched_done, 0);
   endtask

   initial begin
      int bad;
      bus.line_start = 1'b0;
      bus.target_line = '0;
      clear_table();
      repeat (3) @(negedge clk);
      chk_zero("reset_state");
      reset = 1'b0;
      @(negedge clk);
      chk_zero("idle_after_reset");

      clear_table();
      mem[5] = obj(100, 40, 3, 1);
      scan_line(50, "single");

      clear_table();
      mem[0] = obj(11, 169, 1, 1);
      mem[1] = obj(22, 168, 2, 1);
      mem[2] = obj(33, 200, 3, 1);
      mem[3] = obj(44, 201, 4, 1);
      mem[4] = obj(55, 4090, 5, 1);
      mem[5] = obj(66, 190, 6, 0);
      scan_line(200, "bound");

      clear_table();
      for (int i = 0; i < 10; i++) mem[i] = obj(i * 10, 0, i, 1);
      scan_line(0, "overflow");

      clear_table();
      for (int i = 0; i < MAX; i++) mem[i] = obj(i, 50, 1, 0);
      scan_line(50, "no_hits");

      for (int t = 0; t < 6; t++) begin
         int line;
         line = int'($urandom_range(0, 1023));
         gen_table(line, 15 * (t + 1));
         scan_line(line, "random");
      end

      // restart at T+20: only line-60 hits may be written, one done
      gen_table(10, 60);
      for (int i = 0; i < 20; i++) mem[i][0] = 1'b0;
      for (int j = 0; j < 7; j++) mem[20 + 3 * j] = obj(j * 7, 60 - 4 * j, j, 1);
      partial(10, 19);
      scan_line(60, "restart");

      // restart in the last drain cycle suppresses the done of the old scan
      clear_table();
      mem[5] = obj(100, 40, 3, 1);
      partial(50, MAX + 1);
      scan_line(50, "restart_drain");

      // asynchronous reset in the middle of a scan
      gen_table(300, 50);
      for (int i = 0; i < 50; i++) mem[i][0] = 1'b0;
      partial(300, 49);
      @(posedge clk);
      #2 reset = 1'b1;
      #1 chk_zero("async_reset_mid_scan");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      bad = 0;
      for (int n = 0; n < MAX + 10; n++) begin
         @(negedge clk);
         if (bus.sched_done || bus.busy) bad++;
      end
      chk("no_done_after_reset", bad, 0);
      scan_line(300, "after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
